// File: rtl/ped_pass_request.sv
// Pedestrian button front end for traffic_light: synchronises and debounces the
// raw button, holds one accepted request until the green lamp is off, then
// issues a single pass pulse followed by a cooldown window.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | waiting for a debounced press
// ST_PENDING  | request accepted, waiting for light_g to drop
// ST_ISSUE    | pass pulse cycle
// ST_COOLDOWN | presses ignored until cd_cnt reaches COOLDOWN_CYCLES-1
module ped_pass_request #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       light_g,
  output logic       pass,
  output logic       req_pending,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CD_W = $clog2(COOLDOWN_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_ISSUE,
    ST_COOLDOWN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   btn_db_q, btn_db_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   press;
  state_t                 state_q, state_d;
  logic [CD_W-1:0]        cd_cnt_q, cd_cnt_d;
  logic [7:0]             press_count_q, press_count_d;

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive
  // differing samples; the press event fires on the same edge as the rise.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    press    = 1'b0;
    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = '0;
      press    = btn_s;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Request FSM next state, cooldown timer and saturating press counter.
  always_comb begin
    state_d       = state_q;
    cd_cnt_d      = cd_cnt_q;
    press_count_d = press_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_PENDING;
          if (press_count_q != 8'hFF) press_count_d = press_count_q + 8'd1;
        end
      end
      ST_PENDING: begin
        if (!light_g) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d  = ST_COOLDOWN;
        cd_cnt_d = '0;
      end
      ST_COOLDOWN: begin
        cd_cnt_d = cd_cnt_q + CD_W'(1);
        if (cd_cnt_q == CD_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All registered state; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db_q      <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= ST_IDLE;
      cd_cnt_q      <= '0;
      press_count_q <= 8'd0;
    end else begin
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      cd_cnt_q      <= cd_cnt_d;
      press_count_q <= press_count_d;
    end
  end

  assign pass        = (state_q == ST_ISSUE);
  assign req_pending = (state_q == ST_PENDING);
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_COOLDOWN);
  assign press_count = press_count_q;

endmodule

// File: tb/tb_ped_pass_request.sv
// Bench for ped_pass_request: a behavioural model (delay line, sample window,
// busy countdown) is compared with the DUT outputs on every falling edge,
// plus directed literal checks of latency, spacing, reset and saturation.
module tb_ped_pass_request;

  localparam int SYNC = 2;
  localparam int DB   = 16;
  localparam int CD   = 256;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       light_g;
  logic       pass;
  logic       req_pending;
  logic       busy;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pass_seen = 0;

  ped_pass_request #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .light_g    (light_g),
    .pass       (pass),
    .req_pending(req_pending),
    .busy       (busy),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pipe[SYNC];
  bit m_hist[$];
  bit m_db;
  bit m_pending;
  int m_busy_left;
  int m_count;
  bit m_s;
  bit m_press;
  bit m_same;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
        m_hist.delete();
        m_db        = 1'b0;
        m_pending   = 1'b0;
        m_busy_left = 0;
        m_count     = 0;
      end else begin
        // raw value sampled SYNC edges ago is what the debouncer sees now
        m_s = m_pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = btn_raw;
        m_hist.push_back(m_s);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        m_press = 1'b0;
        if (m_hist.size() == DB && m_s != m_db) begin
          m_same = 1'b1;
          foreach (m_hist[i]) if (m_hist[i] != m_s) m_same = 1'b0;
          if (m_same) begin
            m_db    = m_s;
            m_press = m_s;
          end
        end
        if (m_busy_left > 0) begin
          m_busy_left--;
        end else if (m_pending) begin
          if (!light_g) begin
            m_pending   = 1'b0;
            m_busy_left = CD + 1;
          end
        end else if (m_press) begin
          m_pending = 1'b1;
          if (m_count < 255) m_count++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (pass === 1'b1) pass_seen++;
      chk("pass", 32'(pass), 32'(m_busy_left == CD + 1));
      chk("req_pending", 32'(req_pending), 32'(m_pending));
      chk("busy", 32'(busy), 32'(m_busy_left > 0));
      chk("press_count", 32'(press_count), 32'(m_count));
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int busy_cycles;
    int p0;
    int t;
    int k_pass;

    rst = 1'b1; btn_raw = 1'b0; light_g = 1'b0;
    step(3);
    chk("reset pass", 32'(pass), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset count", 32'(press_count), 0);
    rst = 1'b0;
    step(30);

    // clean press: edge 0 is the first edge sampling btn_raw high
    btn_raw = 1'b1;
    busy_cycles = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1);
      if (busy === 1'b1) busy_cycles++;
      if (k - 1 == 16) chk("clean req before edge17", 32'(req_pending), 0);
      if (k - 1 == 17) chk("clean req at edge17", 32'(req_pending), 1);
      if (k - 1 == 17) chk("clean pass at edge17", 32'(pass), 0);
      if (k - 1 == 18) chk("clean pass at edge18", 32'(pass), 1);
      if (k - 1 == 19) chk("clean pass at edge19", 32'(pass), 0);
    end
    chk("clean busy cycles", busy_cycles, 257);
    chk("clean count", 32'(press_count), 1);
    btn_raw = 1'b0;
    step(40);

    // bounce: toggle every 5 cycles
    p0 = pass_seen;
    for (int i = 0; i < 20; i++) begin
      btn_raw = ~btn_raw;
      step(5);
    end
    btn_raw = 1'b0;
    step(40);
    chk("bounce pass pulses", pass_seen - p0, 0);
    chk("bounce count", 32'(press_count), 1);

    // green hold-off
    light_g = 1'b1;
    btn_raw = 1'b1;
    t = 0;
    while (req_pending !== 1'b1 && t < 100) begin step(1); t++; end
    chk("green req timeout", 32'(t < 100), 1);
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("green req held", 32'(req_pending), 1);
      chk("green no pass", 32'(pass), 0);
    end
    light_g = 1'b0;
    step(1);
    chk("green pass after drop", 32'(pass), 1);
    btn_raw = 1'b0;
    chk("green count", 32'(press_count), 2);

    // press during cooldown is ignored, press after cooldown is accepted
    step(80);
    btn_raw = 1'b1;
    step(30);
    btn_raw = 1'b0;
    chk("cooldown busy during 2nd press", 32'(busy), 1);
    t = 0;
    while (busy !== 1'b0 && t < 300) begin step(1); t++; end
    chk("cooldown end timeout", 32'(t < 300), 1);
    chk("cooldown ignored count", 32'(press_count), 2);
    step(5);
    btn_raw = 1'b1;
    t = 0;
    while (pass !== 1'b1 && t < 100) begin step(1); t++; end
    chk("third press pass timeout", 32'(t < 100), 1);
    chk("third press count", 32'(press_count), 3);
    btn_raw = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin step(1); t++; end
    step(20);

    // reset while pending, then while cooling down, button held
    light_g = 1'b1;
    btn_raw = 1'b1;
    t = 0;
    while (req_pending !== 1'b1 && t < 100) begin step(1); t++; end
    chk("rst pending reached", 32'(req_pending), 1);
    for (int r = 0; r < 2; r++) begin
      rst = 1'b1;
      step(1);
      chk("rst edge pass", 32'(pass), 0);
      chk("rst edge req", 32'(req_pending), 0);
      chk("rst edge busy", 32'(busy), 0);
      chk("rst edge count", 32'(press_count), 0);
      rst = 1'b0;
      light_g = 1'b0;
      k_pass = 0;
      for (int k = 1; k <= 40; k++) begin
        step(1);
        if (pass === 1'b1 && k_pass == 0) k_pass = k;
      end
      chk("rst re-press latency", k_pass - 1, 18);
      if (r == 0) chk("rst cooldown busy", 32'(busy), 1);
    end
    btn_raw = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin step(1); t++; end
    step(30);

    // randomized segments
    for (int seg = 0; seg < 150; seg++) begin
      btn_raw = 1'($urandom_range(0, 1));
      light_g = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(1, 40));
    end

    // saturation: 260 accepted presses back to back
    btn_raw = 1'b0;
    light_g = 1'b0;
    step(20);
    t = 0;
    while ((m_busy_left != 0 || m_pending) && t < 400) begin step(1); t++; end
    step(20);
    for (int n = 0; n < 260; n++) begin
      btn_raw = 1'b1;
      t = 0;
      while (m_busy_left != CD + 1 && t < 400) begin step(1); t++; end
      if (t >= 400) chk("saturation press timeout", 32'(t), 0);
      btn_raw = 1'b0;
      t = 0;
      while (m_busy_left > 10 && t < 400) begin step(1); t++; end
    end
    t = 0;
    while (busy !== 1'b0 && t < 300) begin step(1); t++; end
    chk("saturation count", 32'(press_count), 255);
    chk("saturation model count", m_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
